// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the memory-slave state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01,
        HR_RETRY = 2'b10,
        HR_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [2:0] {
        HS_BYTE = 3'd0,
        HS_HALF = 3'd1,
        HS_WORD = 3'd2
    } hsize_t;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_t;

endpackage

// File: rtl/ahb_byte_lane_mem.sv
// Word-wide storage with per-byte write enables and an asynchronous read port.
module ahb_byte_lane_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          hclk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata_c
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately left unreset so they survive a bus reset.
    always_ff @(posedge hclk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory slave: decodes address phases, inserts wait states, returns two-cycle
// ERROR responses for illegal accesses and serves reads/writes from a byte-lane memory.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic        hready_in,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic [3:0]  hmaster,
    input  logic        hmastlock,
    output logic        hready,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW         = 4;
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_DEPTH * 4);
    localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_STATES - 1);

    slv_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [3:0]    master_q;

    logic          accept;
    logic          addr_err;
    logic          load;
    logic          wr_en;
    logic [3:0]    be;
    logic [AW-1:0] rd_idx;
    logic [31:0]   mem_rdata;
    logic [31:0]   rd_word;
    logic          hready_d;
    logic [1:0]    hresp_d;
    logic [31:0]   hrdata_d;

    // Address phases are only considered while this slave is not stalling the bus.
    assign accept = hsel & hready_in & htrans[1] &
                    ((state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2));

    assign addr_err = (haddr >= ADDR_LIMIT)
                    | (hsize > 3'd2)
                    | ((hsize == 3'd1) & haddr[0])
                    | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    load = 1'b1;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // Little-endian lane enables for the write completing in the current data phase.
    always_comb begin
        be = 4'b1111;
        case (size_q)
            HS_BYTE: be = 4'b0001 << addr_q[1:0];
            HS_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign wr_en  = (state_q == ST_DATA) & write_q;
    assign rd_idx = load ? haddr[AW+1:2] : addr_q[AW+1:2];

    ahb_byte_lane_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .hclk    (hclk),
        .we      (wr_en),
        .be      (be),
        .waddr   (addr_q[AW+1:2]),
        .wdata   (hwdata),
        .raddr   (rd_idx),
        .rdata_c (mem_rdata)
    );

    // A write committing on the same edge must be visible to the read being registered.
    always_comb begin
        rd_word = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i] && (addr_q[AW+1:2] == rd_idx)) begin
                rd_word[i*8 +: 8] = hwdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        hrdata_d = '0;
        if ((state_d == ST_WAIT) || (state_d == ST_ERR1)) begin
            hready_d = 1'b0;
        end
        if ((state_d == ST_ERR1) || (state_d == ST_ERR2)) begin
            hresp_d = HRESP_ERROR;
        end
        if (state_d == ST_DATA) begin
            hrdata_d = rd_word;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            master_q <= '0;
            hready   <= 1'b1;
            hresp    <= HRESP_OKAY;
            hrdata   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                addr_q   <= haddr;
                write_q  <= hwrite;
                size_q   <= hsize;
                master_q <= hmaster;
            end
            hready <= hready_d;
            hresp  <= hresp_d;
            hrdata <= hrdata_d;
        end
    end

    // Informational inputs and captured-but-unconsumed fields.
    logic unused_sig;
    assign unused_sig = ^{hburst, hmastlock, htrans[0], master_q, addr_q[31:AW+2]};

endmodule
